// File: rtl/bcd_pkg.sv
// Shared encodings for the BCD up/down sequencer: command ops, FSM states, digit limit.
// Pure declarations; no timing or flow-control behaviour of its own.
package bcd_pkg;

   typedef enum logic [1:0] {
      OP_LOAD      = 2'd0,
      OP_SET_LIMIT = 2'd1,
      OP_START     = 2'd2,
      OP_STOP      = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the counter chain: steps up or down by one when enabled.
// Purely combinational; carry/borrow out is only raised while enabled.
module bcd_digit_step
   import bcd_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       en_i,
   input  logic       dir_i,
   output logic [3:0] digit_o,
   output logic       cout_o
);

   always_comb begin
      digit_o = digit_i;
      cout_o  = 1'b0;
      if (en_i) begin
         if (dir_i) begin
            if (digit_i >= BCD_MAX) begin
               digit_o = 4'd0;
               cout_o  = 1'b1;
            end else begin
               digit_o = digit_i + 4'd1;
            end
         end else begin
            if (digit_i == 4'd0) begin
               digit_o = BCD_MAX;
               cout_o  = 1'b1;
            end else begin
               digit_o = digit_i - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_updown_sequencer.sv
// Command-driven multi-digit BCD up/down counter with limit stop; all outputs registered, one-cycle latency.
// Accepts at most one command every other cycle (cmd_ready drops for one cycle after each accept).
module bcd_updown_sequencer
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [1:0]            cmd_op_i,
   input  logic                  cmd_dir_i,
   input  logic [4*DIGITS-1:0]   cmd_data_i,
   input  logic                  tick_i,
   output logic [4*DIGITS-1:0]   count_o,
   output logic                  running_o,
   output logic                  dir_o,
   output logic                  done_o,
   output logic                  wrap_o,
   output logic                  cmd_err_o
);

   localparam int unsigned W = 4 * DIGITS;

   state_e          state_q, state_d;
   logic [W-1:0]    count_q, count_d;
   logic [W-1:0]    limit_q, limit_d;
   logic            dir_q, dir_d;
   logic            ready_q, ready_d;
   logic            running_q, running_d;
   logic            done_q, done_d;
   logic            wrap_q, wrap_d;
   logic            err_q, err_d;

   logic            accept;
   logic            data_ok;
   logic [W-1:0]    step_count;
   logic [DIGITS:0] en_chain;
   logic [DIGITS-1:0] cout;

   assign accept = cmd_valid_i & ready_q;

   // An accepted command owns the cycle, so a coincident tick is dropped.
   assign en_chain[0] = tick_i & running_q & ~accept;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit_step u_step (
         .digit_i (count_q[4*k +: 4]),
         .en_i    (en_chain[k]),
         .dir_i   (dir_q),
         .digit_o (step_count[4*k +: 4]),
         .cout_o  (cout[k])
      );
      assign en_chain[k+1] = en_chain[k] & cout[k];
   end

   always_comb begin
      data_ok = 1'b1;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (cmd_data_i[4*k +: 4] > BCD_MAX) data_ok = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      limit_d = limit_q;
      dir_d   = dir_q;
      ready_d = 1'b1;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (accept) begin
         ready_d = 1'b0;
         case (op_e'(cmd_op_i))
            OP_LOAD: begin
               if (data_ok) begin
                  count_d = cmd_data_i;
                  if (state_q == ST_DONE) state_d = ST_IDLE;
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_SET_LIMIT: begin
               if (data_ok) limit_d = cmd_data_i;
               else         err_d   = 1'b1;
            end
            OP_START: begin
               dir_d   = cmd_dir_i;
               state_d = ST_RUN;
            end
            OP_STOP: state_d = ST_IDLE;
         endcase
      end else if (en_chain[0]) begin
         count_d = step_count;
         // Carry/borrow escaping the top digit means a full-range wrap.
         wrap_d  = en_chain[DIGITS];
         if (step_count == limit_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
      end
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         limit_q   <= '0;
         dir_q     <= 1'b1;
         ready_q   <= 1'b1;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         limit_q   <= limit_d;
         dir_q     <= dir_d;
         ready_q   <= ready_d;
         running_q <= running_d;
         done_q    <= done_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
      end
   end

   assign cmd_ready_o = ready_q;
   assign count_o     = count_q;
   assign running_o   = running_q;
   assign dir_o       = dir_q;
   assign done_o      = done_q;
   assign wrap_o      = wrap_q;
   assign cmd_err_o   = err_q;

endmodule

// File: tb/tb_bcd_updown_sequencer.sv
// Directed bench for bcd_updown_sequencer: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_bcd_updown_sequencer;
   import bcd_pkg::*;

   typedef struct packed {
      logic [15:0] count;
      logic        run;
      logic        dir;
      logic        done;
      logic        wrap;
      logic        err;
      logic        rdy;
   } obs_t;

   typedef struct {
      int    cyc;
      string name;
      obs_t  exp;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i = 2'd0;
   logic        cmd_dir_i = 1'b0;
   logic [15:0] cmd_data_i = 16'h0;
   logic        tick_i = 1'b0;
   logic [15:0] count_o;
   logic        running_o, dir_o, done_o, wrap_o, cmd_err_o;

   int   total = 0;
   int   bad = 0;
   int   cyc_cnt = 0;
   exp_t sb[$];

   bcd_updown_sequencer #(.DIGITS(4)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_op_i    (cmd_op_i),
      .cmd_dir_i   (cmd_dir_i),
      .cmd_data_i  (cmd_data_i),
      .tick_i      (tick_i),
      .count_o     (count_o),
      .running_o   (running_o),
      .dir_o       (dir_o),
      .done_o      (done_o),
      .wrap_o      (wrap_o),
      .cmd_err_o   (cmd_err_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

   function automatic obs_t mk(input logic [15:0] c, input logic run, input logic d,
                               input logic dn, input logic wr, input logic er, input logic rd);
      return '{count: c, run: run, dir: d, done: dn, wrap: wr, err: er, rdy: rd};
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("count=%h run=%b dir=%b done=%b wrap=%b err=%b rdy=%b",
                       o.count, o.run, o.dir, o.done, o.wrap, o.err, o.rdy);
   endfunction

   function automatic obs_t sample();
      return mk(count_o, running_o, dir_o, done_o, wrap_o, cmd_err_o, cmd_ready_o);
   endfunction

   task automatic chk(input string name, input obs_t act, input obs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
      end
   endtask

   always @(negedge clk_i) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
         exp_t e;
         e = sb.pop_front();
         if (e.cyc < cyc_cnt) begin
            total++;
            bad++;
            $display("FAIL %s: expectation stale at cycle %0d, wanted cycle %0d", e.name, cyc_cnt, e.cyc);
         end else begin
            chk(e.name, sample(), e.exp);
         end
      end
   end

   // Called at posedge+1; drives one cycle and books the result seen after the next edge.
   task automatic drive(input logic v, input logic [1:0] op, input logic d, input logic [15:0] data,
                        input logic t, input string name, input obs_t e);
      exp_t x;
      cmd_valid_i = v;
      cmd_op_i    = op;
      cmd_dir_i   = d;
      cmd_data_i  = data;
      tick_i      = t;
      x.cyc  = cyc_cnt + 1;
      x.name = name;
      x.exp  = e;
      sb.push_back(x);
      @(posedge clk_i);
      #1;
   endtask

   // Accepted command followed by an idle cycle in which cmd_ready returns.
   task automatic cmd(input op_e op, input logic d, input logic [15:0] data, input string name,
                      input logic [15:0] c, input logic run, input logic ed, input logic er);
      drive(1'b1, op, d, data, 1'b0, name, mk(c, run, ed, 1'b0, 1'b0, er, 1'b0));
      drive(1'b0, 2'd0, 1'b0, 16'h0, 1'b0, {name, "_gap"}, mk(c, run, ed, 1'b0, 1'b0, 1'b0, 1'b1));
   endtask

   task automatic tk(input string name, input logic [15:0] c, input logic run, input logic ed,
                     input logic dn, input logic wr);
      drive(1'b0, 2'd0, 1'b0, 16'h0, 1'b1, name, mk(c, run, ed, dn, wr, 1'b0, 1'b1));
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 16'h0, 1'b0, "reset_state", mk(16'h0000, 0, 1, 0, 0, 0, 1));

      // Carry ripple across two digits
      cmd(OP_LOAD, 1'b0, 16'h0198, "load_0198", 16'h0198, 0, 1, 0);
      cmd(OP_START, 1'b1, 16'h0, "start_up", 16'h0198, 1, 1, 0);
      tk("up_0199", 16'h0199, 1, 1, 0, 0);
      tk("up_0200", 16'h0200, 1, 1, 0, 0);
      tk("up_0201", 16'h0201, 1, 1, 0, 0);

      // Down wrap then stop at limit
      cmd(OP_LOAD, 1'b0, 16'h0000, "load_0000_run", 16'h0000, 1, 1, 0);
      cmd(OP_SET_LIMIT, 1'b0, 16'h9990, "limit_9990", 16'h0000, 1, 1, 0);
      cmd(OP_START, 1'b0, 16'h0, "start_down", 16'h0000, 1, 0, 0);
      tk("down_wrap_9999", 16'h9999, 1, 0, 0, 1);
      for (int i = 1; i <= 8; i++) tk("down_step", 16'h9999 - 16'(i), 1, 0, 0, 0);
      tk("down_done_9990", 16'h9990, 0, 0, 1, 0);
      tk("done_tick_ignored", 16'h9990, 0, 0, 0, 0);

      // Invalid BCD rejected, then valid limit accepted
      cmd(OP_LOAD, 1'b0, 16'h12A4, "load_bad_12a4", 16'h9990, 0, 0, 1);
      cmd(OP_SET_LIMIT, 1'b0, 16'h0005, "limit_0005", 16'h9990, 0, 0, 0);

      // Command beats a same-cycle tick
      cmd(OP_LOAD, 1'b0, 16'h0040, "load_0040_done", 16'h0040, 0, 0, 0);
      cmd(OP_START, 1'b1, 16'h0, "start_up2", 16'h0040, 1, 1, 0);
      tk("up_0041", 16'h0041, 1, 1, 0, 0);
      drive(1'b1, OP_LOAD, 1'b0, 16'h0007, 1'b1, "load_with_tick", mk(16'h0007, 1, 1, 0, 0, 0, 0));
      tk("up_0008", 16'h0008, 1, 1, 0, 0);
      cmd(OP_STOP, 1'b0, 16'h0, "stop_run", 16'h0008, 0, 1, 0);

      // Back-to-back commands with cmd_valid held high
      drive(1'b1, OP_LOAD, 1'b0, 16'h0050, 1'b0, "b2b_load", mk(16'h0050, 0, 1, 0, 0, 0, 0));
      drive(1'b1, OP_SET_LIMIT, 1'b0, 16'h0060, 1'b0, "b2b_lim_wait", mk(16'h0050, 0, 1, 0, 0, 0, 1));
      drive(1'b1, OP_SET_LIMIT, 1'b0, 16'h0060, 1'b0, "b2b_lim_acc", mk(16'h0050, 0, 1, 0, 0, 0, 0));
      drive(1'b1, OP_START, 1'b1, 16'h0, 1'b0, "b2b_start_wait", mk(16'h0050, 0, 1, 0, 0, 0, 1));
      drive(1'b1, OP_START, 1'b1, 16'h0, 1'b0, "b2b_start_acc", mk(16'h0050, 1, 1, 0, 0, 0, 0));
      drive(1'b1, OP_STOP, 1'b0, 16'h0, 1'b1, "b2b_stop_wait", mk(16'h0051, 1, 1, 0, 0, 0, 1));
      drive(1'b1, OP_STOP, 1'b0, 16'h0, 1'b1, "b2b_stop_acc", mk(16'h0051, 0, 1, 0, 0, 0, 0));
      tk("idle_tick_ignored", 16'h0051, 0, 1, 0, 0);

      // Limit 0060 from the back-to-back burst, reached across a carry
      cmd(OP_START, 1'b1, 16'h0, "start_up3", 16'h0051, 1, 1, 0);
      for (int i = 1; i <= 8; i++) tk("up_to_limit", 16'h0051 + 16'(i), 1, 1, 0, 0);
      tk("up_done_0060", 16'h0060, 0, 1, 1, 0);

      // Up wrap from all nines, then down wrap
      cmd(OP_LOAD, 1'b0, 16'h9999, "load_9999", 16'h9999, 0, 1, 0);
      cmd(OP_START, 1'b1, 16'h0, "start_up4", 16'h9999, 1, 1, 0);
      tk("up_wrap_0000", 16'h0000, 1, 1, 0, 1);
      cmd(OP_START, 1'b0, 16'h0, "restart_down", 16'h0000, 1, 0, 0);
      tk("down_wrap2", 16'h9999, 1, 0, 0, 1);

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk_i);
      #1;
      // Asynchronous reset mid-run with a command pending, checked before any edge
      cmd_valid_i = 1'b1;
      cmd_op_i    = OP_LOAD;
      cmd_data_i  = 16'h0123;
      rst_ni      = 1'b0;
      #2;
      chk("async_reset", sample(), mk(16'h0000, 0, 1, 0, 0, 0, 1));
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
      rst_ni      = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 16'h0, 1'b0, "after_reset", mk(16'h0000, 0, 1, 0, 0, 0, 1));

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk_i);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
